// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles 5-byte command frames {SYNC, CMD, DATA_HI, DATA_LO, CHK}
// from the UART RX byte stream. It presents a frame only when CHK == CMD ^ DATA_HI ^ DATA_LO.
//
// Ports:
//   i_CLK        system clock (same domain as UART RX)
//   i_RESET_n    asynchronous active-low reset
//   i_RX_DV      one-cycle strobe, i_RX_BYTE valid
//   i_RX_BYTE    received byte
//   o_CMD        command byte of last good frame
//   o_DATA       {DATA_HI, DATA_LO} of last good frame
//   o_CMD_VALID  one-cycle pulse, new good frame
//   o_FRAME_ERR  one-cycle pulse, checksum mismatch
//   o_TIMEOUT    one-cycle pulse, frame abandoned due to inter-byte gap
//   o_ERR_COUNT  saturating count of frame errors plus timeouts
//   o_BUSY       high while a frame is in progress
module uart_cmd_parser #(
    parameter logic [7:0]  c_SYNC_BYTE      = 8'hAA,
    parameter int unsigned c_TIMEOUT_CYCLES = 21700
) (
    input  logic        i_CLK,
    input  logic        i_RESET_n,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_BYTE,
    output logic [7:0]  o_CMD,
    output logic [15:0] o_DATA,
    output logic        o_CMD_VALID,
    output logic        o_FRAME_ERR,
    output logic        o_TIMEOUT,
    output logic [7:0]  o_ERR_COUNT,
    output logic        o_BUSY
);

    localparam int unsigned CNT_W = (c_TIMEOUT_CYCLES > 2) ? $clog2(c_TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(c_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DHI,
        S_DLO,
        S_CHK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] gap_cnt;
    logic [7:0]       cmd_q;
    logic [7:0]       dhi_q;
    logic [7:0]       dlo_q;

    logic chk_ok_c;
    logic timeout_hit_c;
    logic err_event_c;

    // Checksum, gap-limit and error-event decode for the current cycle
    always_comb begin
        chk_ok_c      = (i_RX_BYTE == (cmd_q ^ dhi_q ^ dlo_q));
        timeout_hit_c = (state != S_IDLE) && !i_RX_DV && (gap_cnt == CNT_LAST);
        err_event_c   = timeout_hit_c || ((state == S_CHK) && i_RX_DV && !chk_ok_c);
    end

    // Frame state machine, gap timer, shadow registers and registered outputs
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state       <= S_IDLE;
            gap_cnt     <= '0;
            cmd_q       <= '0;
            dhi_q       <= '0;
            dlo_q       <= '0;
            o_CMD       <= '0;
            o_DATA      <= '0;
            o_CMD_VALID <= 1'b0;
            o_FRAME_ERR <= 1'b0;
            o_TIMEOUT   <= 1'b0;
            o_ERR_COUNT <= '0;
            o_BUSY      <= 1'b0;
        end else begin
            o_CMD_VALID <= 1'b0;
            o_FRAME_ERR <= 1'b0;
            o_TIMEOUT   <= 1'b0;

            // Gap timer runs only inside a frame; any byte restarts it
            if (state == S_IDLE || i_RX_DV) begin
                gap_cnt <= '0;
            end else if (!timeout_hit_c) begin
                gap_cnt <= gap_cnt + CNT_W'(1);
            end else begin
                gap_cnt   <= '0;
                state     <= S_IDLE;
                o_BUSY    <= 1'b0;
                o_TIMEOUT <= 1'b1;
                cmd_q     <= '0;
                dhi_q     <= '0;
                dlo_q     <= '0;
            end

            if (err_event_c && (o_ERR_COUNT != 8'hFF)) begin
                o_ERR_COUNT <= o_ERR_COUNT + 8'd1;
            end

            // Byte handling; SYNC is only recognised in IDLE, elsewhere it is data
            if (i_RX_DV) begin
                case (state)
                    S_IDLE: begin
                        if (i_RX_BYTE == c_SYNC_BYTE) begin
                            state  <= S_CMD;
                            o_BUSY <= 1'b1;
                        end
                    end
                    S_CMD: begin
                        cmd_q <= i_RX_BYTE;
                        state <= S_DHI;
                    end
                    S_DHI: begin
                        dhi_q <= i_RX_BYTE;
                        state <= S_DLO;
                    end
                    S_DLO: begin
                        dlo_q <= i_RX_BYTE;
                        state <= S_CHK;
                    end
                    S_CHK: begin
                        if (chk_ok_c) begin
                            o_CMD       <= cmd_q;
                            o_DATA      <= {dhi_q, dlo_q};
                            o_CMD_VALID <= 1'b1;
                        end else begin
                            o_FRAME_ERR <= 1'b1;
                        end
                        state  <= S_IDLE;
                        o_BUSY <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        o_BUSY <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Consumes the byte stream from the UART receiver (i_RX_DV / i_RX_BYTE) and assembles fixed 5-byte controller command frames: SYNC, CMD, DATA_HI, DATA_LO, CHK. A frame is accepted only if its checksum is valid. Accepted frames are presented as a registered command/data word with a one-cycle valid strobe. It sits directly downstream of the UART RX stage in the game controller top, and feeds the display, LED and game logic.

Parameters:
c_SYNC_BYTE, 8'hAA, frame start marker
c_TIMEOUT_CYCLES, 21700, maximum idle gap between bytes inside a frame (about 10 byte times at 217 cycles/bit); must be at least 2

Ports:
i_CLK  input  1  system clock (the PLL c0 domain, same as UART RX)
i_RESET_n  input  1  asynchronous active-low reset
i_RX_DV  input  1  one-cycle strobe, i_RX_BYTE valid
i_RX_BYTE  input  8  received byte
o_CMD  output  8  command byte of last good frame
o_DATA  output  16  {DATA_HI, DATA_LO} of last good frame
o_CMD_VALID  output  1  one-cycle pulse, new good frame
o_FRAME_ERR  output  1  one-cycle pulse, checksum mismatch
o_TIMEOUT  output  1  one-cycle pulse, frame abandoned due to gap
o_ERR_COUNT  output  8  saturating count of FRAME_ERR plus TIMEOUT events
o_BUSY  output  1  high while the state is not IDLE

Behaviour:
- Clock and reset: single clock i_CLK; asynchronous active-low reset i_RESET_n.
- Reset values: state IDLE; o_CMD=0; o_DATA=0; all pulses 0; o_ERR_COUNT=0; o_BUSY=0; timeout counter 0.
- State machine: IDLE -> S_CMD -> S_DHI -> S_DLO -> S_CHK -> IDLE.
  - IDLE: on i_RX_DV with byte == c_SYNC_BYTE, go to S_CMD. Any other byte is discarded silently, with no error.
  - S_CMD, S_DHI, S_DLO: on i_RX_DV, capture the byte into a shadow register and advance.
  - S_CHK: on i_RX_DV, compare the byte with CMD ^ DATA_HI ^ DATA_LO.
    - Match: copy the shadow registers to o_CMD/o_DATA and pulse o_CMD_VALID.
    - Mismatch: pulse o_FRAME_ERR; o_CMD/o_DATA are unchanged.
    - Either way, return to IDLE.
- Latency: o_CMD_VALID and o_FRAME_ERR assert the cycle after the i_RX_DV of the CHK byte, for exactly 1 cycle. o_CMD/o_DATA update on that same edge and hold until the next good frame.
- No resync inside a frame: a byte equal to c_SYNC_BYTE in the CMD, DATA or CHK positions is treated as data.
- Timeout:
  - The counter clears on every i_RX_DV and in IDLE; it increments each cycle otherwise while not in IDLE.
  - When the counter equals c_TIMEOUT_CYCLES-1 and i_RX_DV=0: next cycle return to IDLE, pulse o_TIMEOUT for 1 cycle, discard shadow registers.
  - If i_RX_DV arrives on the same cycle the limit is reached, the byte is accepted and no timeout occurs.
- o_ERR_COUNT:
  - +1 on each o_FRAME_ERR or o_TIMEOUT pulse (they cannot coincide).
  - Saturates at 255, no wrap.
  - Cleared only by reset.
- o_BUSY = (state != IDLE), registered with the state.
- Back-to-back frames: a SYNC byte arriving immediately after CHK (next i_RX_DV) starts a new frame; there is no dead time.
- i_RX_DV held high across consecutive cycles: each high cycle counts as one byte (the upstream stage guarantees single-cycle strobes; the parser does not edge-detect).
- Reset mid-frame: immediate return to IDLE; partial frame lost; no pulses issued.

Test Plan:
1. Good frame: bytes AA,01,12,34,27 (01^12^34=27) -> o_CMD_VALID 1 cycle after the 5th strobe; o_CMD=01, o_DATA=1234; o_ERR_COUNT=0.
2. Bad checksum: AA,01,12,34,28 -> o_FRAME_ERR pulse; o_CMD/o_DATA keep the previous values; o_ERR_COUNT=1.
3. Junk then SYNC, and SYNC as data: 55,00,AA,AA,00,01,AB -> one valid frame with o_CMD=AA, o_DATA=0001; leading bytes ignored; no errors.
4. Timeout: AA,05 then silence for c_TIMEOUT_CYCLES -> o_TIMEOUT pulse; o_BUSY falls; a following good frame AA,02,00,00,02 is accepted with o_CMD=02.
5. Boundary: inside a frame, deliver the next byte exactly on the cycle the counter reaches the limit -> no timeout; frame completes normally. Also check that 300 bad frames give o_ERR_COUNT=255 (saturated).
6. Reset mid-frame: AA,01,12, assert i_RESET_n low for 1 cycle, then 34,27 -> no pulses, outputs 0, state IDLE; a following good frame decodes correctly.
